// File: rtl/rfphoenix_trace_writer_pkg.sv
// ============================================================================
// Module  : rfphoenix_trace_writer_pkg
// Brief   : Shared constants and types for the branch-trace queue writer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rfphoenix_trace_writer_pkg;

    localparam int TRACE_DEPTH = 1024;
    localparam int TRACE_CNT_W = 11;

    typedef logic [31:0] address_t;

    typedef enum logic [1:0] {
        TR_IDLE = 2'd0,
        TR_SYNC = 2'd1,
        TR_RUN  = 2'd2,
        TR_OVF  = 2'd3
    } trace_state_t;

endpackage

`default_nettype wire

// File: rtl/rfphoenix_trace_ram.sv
// ============================================================================
// Module  : rfphoenix_trace_ram
// Brief   : Simple dual-port trace RAM, one write port, registered read port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rfphoenix_trace_ram
    import rfphoenix_trace_writer_pkg::*;
#(
    parameter int DEPTH = TRACE_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  address_t      wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output address_t      rdata
);

    address_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/rfphoenix_trace_writer.sv
// ============================================================================
// Module  : rfphoenix_trace_writer
// Brief   : Producer side of the branch-trace queue (queue 15), FWFT output.
//           Optional macro RFPHOENIX_TRACE_DEDUP_EN suppresses repeated targets.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rfphoenix_trace_writer
    import rfphoenix_trace_writer_pkg::*;
#(
    parameter int DEPTH = TRACE_DEPTH,
    parameter int CNT_W = TRACE_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             commit_valid,
    input  address_t         commit_pc,
    input  logic             commit_taken,
    input  address_t         commit_tgt,
    input  logic             pop,
    output address_t         trace_dout,
    output logic             trace_empty,
    output logic             trace_valid,
    output logic [CNT_W-1:0] trace_count,
    output logic             trace_ovf
);

    localparam int PTR_W = $clog2(DEPTH);

    trace_state_t     state;
    trace_state_t     state_nxt;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             valid_q;
    logic             ovf_q;
    logic             full;
    logic             push_req;
    logic             push_ok;
    logic             pop_ok;
    logic             drop;
    logic             rd_en;
    address_t         push_data;

`ifdef RFPHOENIX_TRACE_DEDUP_EN
    address_t         last_entry;
`endif

    assign full        = (count == CNT_W'(DEPTH));
    assign push_data   = (state == TR_SYNC) ? commit_pc : commit_tgt;
    assign pop_ok      = pop && valid_q && !clr;
    assign push_ok     = push_req && (!full || pop_ok);
    assign drop        = push_req && full && !pop_ok;
    // Head register refills whenever it is empty but the queue is not.
    assign rd_en       = !valid_q && (count != '0) && !clr;

    assign trace_count = count;
    assign trace_empty = (count == '0);
    assign trace_valid = valid_q;
    assign trace_ovf   = ovf_q;

    always_comb begin
        push_req = 1'b0;
        if (en && !clr && commit_valid) begin
            case (state)
                TR_SYNC: push_req = 1'b1;
`ifdef RFPHOENIX_TRACE_DEDUP_EN
                TR_RUN:  push_req = commit_taken && (commit_tgt != last_entry);
`else
                TR_RUN:  push_req = commit_taken;
`endif
                default: push_req = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = TR_IDLE;
        end else if (clr) begin
            state_nxt = TR_SYNC;
        end else begin
            case (state)
                TR_IDLE: state_nxt = TR_SYNC;
                TR_SYNC: state_nxt = drop ? TR_OVF : (push_ok ? TR_RUN : TR_SYNC);
                TR_RUN:  state_nxt = drop ? TR_OVF : TR_RUN;
                TR_OVF:  state_nxt = (count <= CNT_W'(DEPTH - 2)) ? TR_SYNC : TR_OVF;
                default: state_nxt = TR_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= TR_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count   <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
            // A pop always leaves one bubble cycle while the RAM re-reads the head.
            valid_q <= (count != '0) && !pop_ok;
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

`ifdef RFPHOENIX_TRACE_DEDUP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_entry <= '0;
        end else if (clr || (state != TR_SYNC && state_nxt == TR_SYNC)) begin
            last_entry <= '0;
        end else if (push_ok) begin
            last_entry <= push_data;
        end
    end
`endif

    rfphoenix_trace_ram #(
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (push_ok),
        .waddr (wr_ptr),
        .wdata (push_data),
        .re    (rd_en),
        .raddr (rd_ptr),
        .rdata (trace_dout)
    );

endmodule

`default_nettype wire

// File: tb/tb_rfphoenix_trace_writer.sv
// ============================================================================
// Module  : tb_rfphoenix_trace_writer
// Brief   : Directed self-checking bench for rfphoenix_trace_writer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rfphoenix_trace_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        clr;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        commit_taken;
    logic [31:0] commit_tgt;
    logic        pop;
    logic [31:0] trace_dout;
    logic        trace_empty;
    logic        trace_valid;
    logic [10:0] trace_count;
    logic        trace_ovf;

    int compared   = 0;
    int mismatched = 0;

    rfphoenix_trace_writer dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .clr          (clr),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_taken (commit_taken),
        .commit_tgt   (commit_tgt),
        .pop          (pop),
        .trace_dout   (trace_dout),
        .trace_empty  (trace_empty),
        .trace_valid  (trace_valid),
        .trace_count  (trace_count),
        .trace_ovf    (trace_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic commit(input logic taken, input logic [31:0] pc, input logic [31:0] tgt);
        commit_valid = 1'b1;
        commit_taken = taken;
        commit_pc    = pc;
        commit_tgt   = tgt;
        tick();
        commit_valid = 1'b0;
        commit_taken = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!trace_valid && n < 8) begin
            tick();
            n++;
        end
        if (!trace_valid) begin
            check("wait_valid_timeout", {31'b0, trace_valid}, 32'd1);
        end
    endtask

    task automatic pop_one(output logic [31:0] d);
        wait_valid();
        d   = trace_dout;
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        rst = 1'b1; en = 1'b0; clr = 1'b0; pop = 1'b0;
        commit_valid = 1'b0; commit_taken = 1'b0; commit_pc = '0; commit_tgt = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_count", {21'b0, trace_count}, 32'd0);
        check("rst_empty", {31'b0, trace_empty}, 32'd1);
        check("rst_valid", {31'b0, trace_valid}, 32'd0);
        check("rst_dout",  trace_dout, 32'd0);
        check("rst_ovf",   {31'b0, trace_ovf}, 32'd0);

        // First record after enable is a sync record with the full PC.
        en = 1'b1;
        tick();
        commit(1'b0, 32'h1000, 32'h0);
        check("t1_count_push_edge", {21'b0, trace_count}, 32'd1);
        check("t1_valid_push_edge", {31'b0, trace_valid}, 32'd0);
        tick();
        check("t1_valid_next_edge", {31'b0, trace_valid}, 32'd1);
        check("t1_dout", trace_dout, 32'h1000);

        // Taken branches in RUN; non-taken commits are not recorded.
        commit(1'b1, 32'h0, 32'h2000);
        commit(1'b1, 32'h0, 32'h2040);
        commit(1'b1, 32'h0, 32'h2080);
        commit(1'b0, 32'h0, 32'h2100);
        check("t2_count", {21'b0, trace_count}, 32'd4);
        pop_one(d); check("t2_pop0", d, 32'h1000);
        pop_one(d); check("t2_pop1", d, 32'h2000);
        pop_one(d); check("t2_pop2", d, 32'h2040);
        pop_one(d); check("t2_pop3", d, 32'h2080);
        check("t2_empty", {31'b0, trace_empty}, 32'd1);
        pop = 1'b1; tick(); pop = 1'b0;
        check("t2_pop_empty_ignored", {21'b0, trace_count}, 32'd0);

        // Fill to full, overflow, recover through a sync record.
        for (int i = 0; i < 1024; i++) commit(1'b1, 32'h0, 32'h10000 + i);
        check("t3_full_count", {21'b0, trace_count}, 32'd1024);
        check("t3_full_no_ovf", {31'b0, trace_ovf}, 32'd0);
        commit(1'b1, 32'h0, 32'hDEAD);
        check("t3_ovf_count", {21'b0, trace_count}, 32'd1024);
        check("t3_ovf_flag", {31'b0, trace_ovf}, 32'd1);
        commit(1'b1, 32'h0, 32'hBEEF);
        check("t3_ovf_state_no_push", {21'b0, trace_count}, 32'd1024);
        pop_one(d); check("t3_pop0", d, 32'h10000);
        pop_one(d); check("t3_pop1", d, 32'h10001);
        check("t3_count_after_pops", {21'b0, trace_count}, 32'd1022);
        tick();
        commit(1'b1, 32'h3000, 32'hBEEF);
        check("t3_sync_count", {21'b0, trace_count}, 32'd1023);
        for (int i = 0; i < 1022; i++) begin
            pop_one(d);
            check("t3_drain", d, 32'h10002 + i);
        end
        pop_one(d); check("t3_sync_entry", d, 32'h3000);
        check("t3_empty", {31'b0, trace_empty}, 32'd1);
        check("t3_ovf_sticky", {31'b0, trace_ovf}, 32'd1);

        // Full with simultaneous push and pop.
        clr = 1'b1; tick(); clr = 1'b0;
        check("t4_clr_ovf", {31'b0, trace_ovf}, 32'd0);
        check("t4_clr_count", {21'b0, trace_count}, 32'd0);
        commit(1'b0, 32'h5000, 32'h0);
        for (int i = 0; i < 1023; i++) commit(1'b1, 32'h0, 32'h20000 + i);
        check("t4_full", {21'b0, trace_count}, 32'd1024);
        wait_valid();
        check("t4_head", trace_dout, 32'h5000);
        commit_valid = 1'b1; commit_taken = 1'b1; commit_tgt = 32'hABCD0000; pop = 1'b1;
        tick();
        commit_valid = 1'b0; commit_taken = 1'b0; pop = 1'b0;
        check("t4_pushpop_count", {21'b0, trace_count}, 32'd1024);
        check("t4_pushpop_no_ovf", {31'b0, trace_ovf}, 32'd0);
        for (int i = 0; i < 1023; i++) begin
            pop_one(d);
            check("t4_drain", d, 32'h20000 + i);
        end
        pop_one(d); check("t4_last_out", d, 32'hABCD0000);
        check("t4_empty", {31'b0, trace_empty}, 32'd1);

        // clr wins over a simultaneous push and pop.
        for (int i = 0; i < 5; i++) commit(1'b1, 32'h0, 32'h6000 + 4 * i);
        check("t5_count5", {21'b0, trace_count}, 32'd5);
        wait_valid();
        clr = 1'b1; pop = 1'b1;
        commit_valid = 1'b1; commit_taken = 1'b1; commit_tgt = 32'h9999;
        tick();
        clr = 1'b0; pop = 1'b0; commit_valid = 1'b0; commit_taken = 1'b0;
        check("t5_clr_count", {21'b0, trace_count}, 32'd0);
        check("t5_clr_empty", {31'b0, trace_empty}, 32'd1);
        check("t5_clr_valid", {31'b0, trace_valid}, 32'd0);
        check("t5_clr_ovf",   {31'b0, trace_ovf}, 32'd0);
        commit(1'b1, 32'h7000, 32'h7777);
        tick();
        check("t5_sync_valid", {31'b0, trace_valid}, 32'd1);
        check("t5_sync_entry", trace_dout, 32'h7000);

        // Repeated targets: collapsed only with the dedup option.
        commit(1'b1, 32'h0, 32'h4000);
        commit(1'b1, 32'h0, 32'h4000);
        commit(1'b1, 32'h0, 32'h4000);
        commit(1'b1, 32'h0, 32'h4100);
`ifdef RFPHOENIX_TRACE_DEDUP_EN
        check("t6_dedup_count", {21'b0, trace_count}, 32'd3);
`else
        check("t6_nodedup_count", {21'b0, trace_count}, 32'd5);
`endif

        // Asynchronous reset mid-operation, observed before the next clock edge.
        #2 rst = 1'b1;
        #1;
        check("t6_arst_count", {21'b0, trace_count}, 32'd0);
        check("t6_arst_empty", {31'b0, trace_empty}, 32'd1);
        check("t6_arst_valid", {31'b0, trace_valid}, 32'd0);
        check("t6_arst_dout",  trace_dout, 32'd0);
        check("t6_arst_ovf",   {31'b0, trace_ovf}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
